phy_link_speed_ctrl: RTL

MDIO management master that polls the external RGMII PHY for link, speed and duplex. It drives the eth_10mbps select of mii_to_rgmii_adapter, so the adapter's clock and datapath mode follow the negotiated link. It sits beside the adapter in the Ethernet subsystem, owns the PHY MDC/MDIO pins and publishes link status to the MAC/CPU side.

---
 rtl/phy_link_speed_ctrl.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/phy_link_speed_ctrl.sv
// MDIO read master that polls the PHY's BMSR and speed/duplex status registers.
// It publishes link, speed and duplex to the MAC side and drives the adapter's 10 Mb/s select.
//
// Ports:
//   clk, rst_n        system clock; synchronous active-low reset
//   enable, poll_now  periodic polling enable; one-cycle immediate-poll request
//   mdc, mdio_o,      MDIO clock, data out and output enable to the PHY pins
//   mdio_oe, mdio_i   (mdio_i is the pulled-up pad input)
//   busy              a poll sequence is in progress
//   link_up, eth_10mbps, full_duplex, speed_err   status from the last good poll
//   status_valid, mdio_err                        last poll completed cleanly / saw no turnaround
//   status_change     one-cycle pulse when link_up, eth_10mbps or full_duplex changes
module phy_link_speed_ctrl #(
    parameter int         CLK_DIV     = 25,
    parameter int         POLL_CYCLES = 5000000,
    parameter logic [4:0] PHY_ADDR    = 5'd0,
    parameter logic [4:0] STAT_REG    = 5'd31,
    parameter int         SPD10_BIT   = 4,
    parameter int         SPD100_BIT  = 5,
    parameter int         SPD1000_BIT = 6,
    parameter int         DUPLEX_BIT  = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic poll_now,
    output logic mdc,
    output logic mdio_o,
    output logic mdio_oe,
    input  logic mdio_i,
    output logic busy,
    output logic link_up,
    output logic eth_10mbps,
    output logic full_duplex,
    output logic speed_err,
    output logic status_valid,
    output logic status_change,
    output logic mdio_err
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TMR_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BMSR,
        S_STAT,
        S_COMMIT
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [DIV_W-1:0]   r_div;
    logic               r_mdc;
    logic [5:0]         r_bit;
    logic               r_mdio_o;
    logic               r_mdio_oe;
    logic [15:0]        r_data;
    logic               r_bmsr_lnk;
    logic               r_ferr;
    logic [TMR_W-1:0]   r_timer;
    logic               r_first;
    logic               r_pend;
    logic               r_link;
    logic               r_10;
    logic               r_fd;
    logic               r_serr;
    logic               r_valid;
    logic               r_chg;
    logic               r_merr;

    logic               w_frame;
    logic               w_tick;
    logic               w_rise;
    logic               w_fall;
    logic               w_last;
    logic               w_start;
    logic               w_new_frame;
    logic [4:0]         w_reg;
    logic [45:0]        w_hdr;
    logic [5:0]         w_nbit;
    logic [5:0]         w_hidx;
    logic               w_s10;
    logic               w_s100;
    logic               w_s1000;
    logic               w_spd_ok;
    logic               w_link_n;
    logic               w_10_n;
    logic               w_fd_n;
    logic               w_serr_n;
    logic               w_unused_data;

    assign w_frame = (r_state == S_BMSR) || (r_state == S_STAT);
    assign w_tick  = w_frame && (r_div == DIV_W'(CLK_DIV - 1));
    assign w_rise  = w_tick && !r_mdc;
    assign w_fall  = w_tick && r_mdc;
    assign w_last  = w_fall && (r_bit == 6'd63);

    // Header bit b of the current frame is w_hdr[45-b]
    assign w_reg   = (r_state == S_STAT) ? STAT_REG : 5'd1;
    assign w_hdr   = {32'hFFFF_FFFF, 4'b0110, PHY_ADDR, w_reg};
    assign w_nbit  = r_bit + 6'd1;
    assign w_hidx  = 6'd45 - w_nbit;

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_pend || poll_now ||
                    (enable && (r_first ||
                     r_timer == TMR_W'(POLL_CYCLES - 1)))) begin
                    w_next  = S_BMSR;
                    w_start = 1'b1;
                end
            end
            S_BMSR: if (w_last) w_next = S_STAT;
            S_STAT: if (w_last) w_next = S_COMMIT;
            S_COMMIT: begin
                // A request latched during the sequence chains straight on
                if (r_pend || poll_now) begin
                    w_next  = S_BMSR;
                    w_start = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    assign w_new_frame = w_start || ((r_state == S_BMSR) && w_last);

    assign w_s10    = r_data[SPD10_BIT];
    assign w_s100   = r_data[SPD100_BIT];
    assign w_s1000  = r_data[SPD1000_BIT];
    assign w_spd_ok = r_bmsr_lnk && (w_s10 ^ w_s100) && !w_s1000;
    assign w_link_n = r_ferr ? 1'b0 : r_bmsr_lnk;
    assign w_10_n   = (!r_ferr && w_spd_ok) ? w_s10 : r_10;
    assign w_fd_n   = (!r_ferr && w_spd_ok) ? r_data[DUPLEX_BIT] : r_fd;
    assign w_serr_n = r_ferr ? r_serr :
                      (r_bmsr_lnk && (w_s1000 || !(w_s10 ^ w_s100)));
    assign w_unused_data = ^r_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_mdc      <= 1'b0;
            r_bit      <= '0;
            r_mdio_o   <= 1'b1;
            r_mdio_oe  <= 1'b0;
            r_data     <= '0;
            r_bmsr_lnk <= 1'b0;
            r_ferr     <= 1'b0;
            r_timer    <= '0;
            r_first    <= 1'b1;
            r_pend     <= 1'b0;
            r_link     <= 1'b0;
            r_10       <= 1'b0;
            r_fd       <= 1'b0;
            r_serr     <= 1'b0;
            r_valid    <= 1'b0;
            r_chg      <= 1'b0;
            r_merr     <= 1'b0;
        end else begin
            r_chg <= 1'b0;

            if (w_frame) begin
                if (w_tick) begin
                    r_div <= '0;
                    r_mdc <= ~r_mdc;
                end else begin
                    r_div <= r_div + DIV_W'(1);
                end
            end else begin
                r_div <= '0;
                r_mdc <= 1'b0;
            end

            if (w_new_frame) begin
                r_bit     <= '0;
                r_mdio_oe <= 1'b1;
                r_mdio_o  <= 1'b1;
            end else if (w_fall && !w_last) begin
                r_bit <= w_nbit;
                if (w_nbit < 6'd46) begin
                    r_mdio_oe <= 1'b1;
                    r_mdio_o  <= w_hdr[w_hidx];
                end else begin
                    r_mdio_oe <= 1'b0;
                    r_mdio_o  <= 1'b1;
                end
            end

            if (w_start) r_ferr <= 1'b0;
            if (w_rise) begin
                // A released (pulled-up) turnaround means no PHY answered
                if (r_bit == 6'd47 && mdio_i) r_ferr <= 1'b1;
                if (r_bit >= 6'd48) r_data <= {r_data[14:0], mdio_i};
            end
            if ((r_state == S_BMSR) && w_last) r_bmsr_lnk <= r_data[2];

            if (w_start || r_state == S_COMMIT) begin
                r_timer <= '0;
            end else if (r_state == S_IDLE && enable) begin
                r_timer <= r_timer + TMR_W'(1);
            end

            if (w_start) r_first <= 1'b0;

            if (w_start)                            r_pend <= 1'b0;
            else if (poll_now && r_state != S_IDLE) r_pend <= 1'b1;

            if (r_state == S_COMMIT) begin
                r_link  <= w_link_n;
                r_10    <= w_10_n;
                r_fd    <= w_fd_n;
                r_serr  <= w_serr_n;
                r_valid <= !r_ferr;
                r_merr  <= r_ferr;
                r_chg   <= (w_link_n != r_link) || (w_10_n != r_10) ||
                           (w_fd_n != r_fd);
            end
        end
    end

    assign mdc           = r_mdc;
    assign mdio_o        = r_mdio_o;
    assign mdio_oe       = r_mdio_oe;
    assign busy          = (r_state != S_IDLE);
    assign link_up       = r_link;
    assign eth_10mbps    = r_10;
    assign full_duplex   = r_fd;
    assign speed_err     = r_serr;
    assign status_valid  = r_valid;
    assign status_change = r_chg;
    assign mdio_err      = r_merr;

endmodule
